// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick pulse and 50% square wave,
// with shadowed divisor writes that take effect only at a period boundary.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 100000000,
  localparam int LCH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              load_en,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             ld_valid;
  logic [CNT_W-1:0] ld_val;

  // A divisor of zero would never reach terminal count; treat it as 1.
  assign ld_val   = (load_div == '0) ? ONE : load_div;
  assign ld_valid = load_en && (int'(load_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             sq_q;
    logic             busy_q;
    logic             hit;
    logic             tc;

    assign hit = ld_valid && (load_ch == LCH_W'(i));
    assign tc  = (cnt_q == div_q - ONE);

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        div_q    <= DIV_RST;
        shadow_q <= DIV_RST;
        cnt_q    <= '0;
        tick_q   <= 1'b0;
        sq_q     <= 1'b0;
        busy_q   <= 1'b0;
      end else if (sync_clr || !ch_en[i]) begin
        // Counter is parked at zero, so any divisor change is safe to apply now.
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        busy_q <= 1'b0;
        if (hit) begin
          div_q    <= ld_val;
          shadow_q <= ld_val;
        end else if (busy_q) begin
          div_q <= shadow_q;
        end
      end else begin
        if (tc) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          sq_q   <= ~sq_q;
          if (busy_q) div_q <= shadow_q;
        end else begin
          cnt_q  <= cnt_q + ONE;
          tick_q <= 1'b0;
        end
        // A write on the terminal-count cycle lands after the old shadow is applied.
        if (hit) begin
          shadow_q <= ld_val;
          busy_q   <= 1'b1;
        end else if (tc) begin
          busy_q <= 1'b0;
        end
      end
    end

    assign tick_out[i] = tick_q;
    assign sq_out[i]   = sq_q;
    assign busy[i]     = busy_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels, 8-bit counters, default divisor 5).
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int LCH_W  = 2;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              load_en;
  logic [LCH_W-1:0]  load_ch;
  logic [CNT_W-1:0]  load_div;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] sq_out;
  logic [NUM_CH-1:0] busy;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(5)) dut (
    .clk_in(clk_in), .reset(reset), .ch_en(ch_en), .sync_clr(sync_clr),
    .load_en(load_en), .load_ch(load_ch), .load_div(load_div),
    .tick_out(tick_out), .sq_out(sq_out), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [LCH_W-1:0] ch, input logic [CNT_W-1:0] d);
    load_en  = 1'b1;
    load_ch  = ch;
    load_div = d;
  endtask

  initial begin
    reset = 1'b1; ch_en = '0; sync_clr = 1'b0;
    load_en = 1'b0; load_ch = '0; load_div = '0;
    step(); step();
    chk("rst_tick", tick_out, 0);
    chk("rst_sq",   sq_out,   0);
    chk("rst_busy", busy,     0);

    // Default divisor 5: ticks on edges 5,10,15; square toggles there.
    reset = 1'b0; ch_en = 3'b111;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk("def_tick0", tick_out[0], (c % 5 == 0));
      chk("def_sq0",   sq_out[0],   (c / 5) % 2);
      chk("def_tick1", tick_out[1], (c % 5 == 0));
    end

    // Disabled write to ch0 applies at once, busy stays low.
    ch_en[0] = 1'b0; wr(0, 4);
    step(); load_en = 1'b0;
    chk("dis_busy0", busy[0], 0);
    chk("dis_tick0", tick_out[0], 0);
    chk("dis_sq0",   sq_out[0], 0);

    // Enabled, div 4; write 2 at cnt=1: period of 4 completes, then period 2.
    ch_en[0] = 1'b1;
    step();
    wr(0, 2);
    step(); load_en = 1'b0;
    chk("mid_busy_e2", busy[0], 1);
    chk("mid_tick_e2", tick_out[0], 0);
    step();
    chk("mid_busy_e3", busy[0], 1);
    chk("mid_tick_e3", tick_out[0], 0);
    step();
    chk("mid_tick_e4", tick_out[0], 1);
    chk("mid_busy_e4", busy[0], 0);
    chk("mid_sq_e4",   sq_out[0], 1);
    for (int k = 5; k <= 8; k++) begin
      step();
      chk("div2_tick0", tick_out[0], (k % 2 == 0));
    end

    // Load 0 behaves as divisor 1.
    wr(0, 0);
    step(); load_en = 1'b0;
    chk("z_tick_e9", tick_out[0], 0);
    chk("z_busy_e9", busy[0], 1);
    step();
    chk("z_tick_e10", tick_out[0], 1);
    chk("z_busy_e10", busy[0], 0);
    chk("z_sq_e10",   sq_out[0], 0);
    step();
    chk("z_tick_e11", tick_out[0], 1);
    chk("z_sq_e11",   sq_out[0], 1);
    step();
    chk("z_tick_e12", tick_out[0], 1);
    chk("z_sq_e12",   sq_out[0], 0);

    // Out-of-range channel index is ignored.
    wr(3, 7);
    step(); load_en = 1'b0;
    chk("bad_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bad_tick0", tick_out[0], 1);
      chk("bad_busy2", busy, 0);
    end

    // ch1 disabled 7 cycles with a write of 4; first tick 4 cycles after re-enable.
    ch_en[1] = 1'b0; wr(1, 4);
    step(); load_en = 1'b0;
    chk("en_busy1", busy[1], 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("en_off_tick1", tick_out[1], 0);
      chk("en_off_sq1",   sq_out[1], 0);
    end
    ch_en[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("en_on_tick1", tick_out[1], (k % 4 == 0));
    end

    // Pending shadow on ch0 (div 1 -> 4), then sync_clr with ch1 <- 3.
    wr(0, 4);
    step(); load_en = 1'b0;
    chk("sc_pend_busy0", busy[0], 1);
    sync_clr = 1'b1; wr(1, 3);
    step(); sync_clr = 1'b0; load_en = 1'b0;
    chk("sc_tick", tick_out, 0);
    chk("sc_sq",   sq_out,   0);
    chk("sc_busy", busy,     0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("sc_tick0", tick_out[0], (k % 4 == 0));
      chk("sc_tick1", tick_out[1], (k % 3 == 0));
      chk("sc_tick2", tick_out[2], (k % 5 == 0));
    end
    chk("pre_rst_sq", sq_out, 3'b101);

    // Async reset mid-period (ch2 at cnt=2 of div 5), no clock edge needed.
    #3 reset = 1'b1;
    #1;
    chk("arst_tick", tick_out, 0);
    chk("arst_sq",   sq_out,   0);
    chk("arst_busy", busy,     0);
    #1 reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("arst_div", tick_out, (k % 5 == 0) ? 3'b111 : 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
